// File: rtl/bram_capture_writer.sv
// Purpose: capture a fixed number of stream samples into BRAM port A, then hand the BRAM to a reader.
// Latency: one cycle from an accepted sample to its BRAM write strobe; done rises on the edge that
//          registers the last write, and switch drops one edge later.
// Backpressure: none; s_axis_tready is always 1 and samples arriving outside CAPTURE are dropped.
//
// Ports:
//   clk, rst            - single clock; synchronous active-high reset
//   cfg_length          - words to capture; values above the BRAM depth are clamped to the depth
//   start               - one-cycle capture request, honoured in IDLE and DONE, ignored in CAPTURE
//   s_axis_*            - sample stream in (tready tied high)
//   bram_porta_*        - BRAM port A write side; rddata is unused
//   switch              - 1 while the writer owns the BRAM, 0 once it is handed to the reader
//   busy / done         - decoded from the state register (CAPTURE / DONE)
//   sts_count           - words written in the current or most recent capture
module bram_capture_writer #(
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BRAM_ADDR_WIDTH:0]   cfg_length,
    input  logic                       start,
    input  logic [BRAM_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic                       bram_porta_clk,
    output logic                       bram_porta_rst,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_porta_addr,
    output logic [BRAM_DATA_WIDTH-1:0] bram_porta_wrdata,
    output logic                       bram_porta_we,
    input  logic [BRAM_DATA_WIDTH-1:0] bram_porta_rddata,
    output logic                       switch,
    output logic                       busy,
    output logic                       done,
    output logic [BRAM_ADDR_WIDTH:0]   sts_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Full BRAM depth, 2^BRAM_ADDR_WIDTH, expressed in the count width.
    localparam logic [BRAM_ADDR_WIDTH:0] DEPTH = {1'b1, {BRAM_ADDR_WIDTH{1'b0}}};

    state_t                       state_q,   state_d;
    logic [BRAM_ADDR_WIDTH:0]     count_q,   count_d;
    logic [BRAM_ADDR_WIDTH:0]     eff_len_q, eff_len_d;
    logic                         switch_q,  switch_d;
    logic                         we_q,      we_d;
    logic [BRAM_ADDR_WIDTH-1:0]   addr_q,    addr_d;
    logic [BRAM_DATA_WIDTH-1:0]   wrdata_q,  wrdata_d;

    logic [BRAM_ADDR_WIDTH:0]     eff_len_new;
    logic [BRAM_ADDR_WIDTH:0]     count_inc;

    // Read port is not needed by the writer; fold it into a sink so it is visibly consumed.
    logic unused_rddata;
    assign unused_rddata = ^bram_porta_rddata;

    // Pass-through BRAM clock/reset and always-ready stream.
    assign bram_porta_clk = clk;
    assign bram_porta_rst = rst;
    assign s_axis_tready  = 1'b1;

    // Clamp the requested length so the capture never wraps the address space.
    assign eff_len_new = (cfg_length > DEPTH) ? DEPTH : cfg_length;
    assign count_inc   = count_q + {{BRAM_ADDR_WIDTH{1'b0}}, 1'b1};

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        eff_len_d = eff_len_q;
        switch_d  = switch_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wrdata_d  = wrdata_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    eff_len_d = eff_len_new;
                    count_d   = '0;
                    if (eff_len_new != '0) begin
                        state_d  = ST_CAPTURE;
                        switch_d = 1'b1;
                    end else begin
                        state_d  = ST_DONE;
                        switch_d = 1'b0;
                    end
                end
            end

            ST_CAPTURE: begin
                // start is deliberately not looked at here.
                if (s_axis_tvalid) begin
                    we_d     = 1'b1;
                    addr_d   = count_q[BRAM_ADDR_WIDTH-1:0];
                    wrdata_d = s_axis_tdata;
                    count_d  = count_inc;
                    if (count_inc == eff_len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                // The first edge in DONE is the edge where the BRAM samples the final we=1,
                // so dropping switch here never races a pending write.
                switch_d = 1'b0;
                if (start) begin
                    eff_len_d = eff_len_new;
                    count_d   = '0;
                    if (eff_len_new != '0) begin
                        state_d  = ST_CAPTURE;
                        switch_d = 1'b1;
                    end else begin
                        state_d  = ST_DONE;
                    end
                end
            end

            default: begin
                state_d  = ST_IDLE;
                switch_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            eff_len_q <= '0;
            switch_q  <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wrdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            eff_len_q <= eff_len_d;
            switch_q  <= switch_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wrdata_q  <= wrdata_d;
        end
    end

    assign bram_porta_we     = we_q;
    assign bram_porta_addr   = addr_q;
    assign bram_porta_wrdata = wrdata_q;
    assign switch            = switch_q;
    assign busy              = (state_q == ST_CAPTURE);
    assign done              = (state_q == ST_DONE);
    assign sts_count         = count_q;

endmodule

// File: tb/tb_bram_capture_writer.sv
// Purpose: directed bench for bram_capture_writer with a write scoreboard.
// Latency: expected BRAM writes are queued by stimulus and popped by a negedge monitor.
// Backpressure: none exercised; tready is checked to be constantly high.
module tb_bram_capture_writer;

    localparam int DW = 32;
    localparam int AW = 15;

    logic          clk;
    logic          rst;
    logic [AW:0]   cfg_length;
    logic          start;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          bram_porta_clk;
    logic          bram_porta_rst;
    logic [AW-1:0] bram_porta_addr;
    logic [DW-1:0] bram_porta_wrdata;
    logic          bram_porta_we;
    logic [DW-1:0] bram_porta_rddata;
    logic          switch;
    logic          busy;
    logic          done;
    logic [AW:0]   sts_count;

    bram_capture_writer #(
        .BRAM_DATA_WIDTH(DW),
        .BRAM_ADDR_WIDTH(AW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_length        (cfg_length),
        .start             (start),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .bram_porta_clk    (bram_porta_clk),
        .bram_porta_rst    (bram_porta_rst),
        .bram_porta_addr   (bram_porta_addr),
        .bram_porta_wrdata (bram_porta_wrdata),
        .bram_porta_we     (bram_porta_we),
        .bram_porta_rddata (bram_porta_rddata),
        .switch            (switch),
        .busy              (busy),
        .done              (done),
        .sts_count         (sts_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input int addr, input logic [DW-1:0] data);
        wr_t w;
        w.addr = addr[AW-1:0];
        w.data = data;
        exp_q.push_back(w);
    endtask

    // Step to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every observed write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (bram_porta_we === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                         bram_porta_addr, bram_porta_wrdata);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                if (bram_porta_addr !== w.addr || bram_porta_wrdata !== w.data) begin
                    fails++;
                    $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                             bram_porta_addr, bram_porta_wrdata, w.addr, w.data);
                end
            end
        end
    end

    logic gap_pat [5];
    int   exp_cnt;

    initial begin
        rst               = 1'b1;
        start             = 1'b0;
        cfg_length        = '0;
        s_axis_tdata      = '0;
        s_axis_tvalid     = 1'b0;
        bram_porta_rddata = '0;
        gap_pat           = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset state
        cyc();
        cyc();
        chk("rst_busy",   busy, 0);
        chk("rst_done",   done, 0);
        chk("rst_switch", switch, 0);
        chk("rst_we",     bram_porta_we, 0);
        chk("rst_addr",   bram_porta_addr, 0);
        chk("rst_wrdata", bram_porta_wrdata, 0);
        chk("rst_count",  sts_count, 0);
        chk("tready",     s_axis_tready, 1);
        chk("porta_rst",  bram_porta_rst, 1);
        rst = 1'b0;
        cyc();
        chk("porta_rst_low", bram_porta_rst, 0);

        // Basic capture of 4 words from IDLE
        cfg_length = 4;
        start      = 1'b1;
        cyc();
        start = 1'b0;
        chk("basic_busy",   busy, 1);
        chk("basic_switch", switch, 1);
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_axis_tdata = 32'hA0 + i;
            push_wr(i, 32'hA0 + i);
            cyc();
        end
        s_axis_tvalid = 1'b0;
        chk("basic_done",        done, 1);
        chk("basic_busy_low",    busy, 0);
        chk("basic_count",       sts_count, 4);
        chk("basic_switch_held", switch, 1);
        cyc();
        chk("basic_switch_drop", switch, 0);
        chk("basic_done_hold",   done, 1);
        chk("basic_count_hold",  sts_count, 4);

        // Re-arm from DONE, capture 3 words with tvalid gaps; start mid-capture ignored
        cfg_length = 3;
        start      = 1'b1;
        cyc();
        start = 1'b0;
        chk("rearm_done_low", done, 0);
        chk("rearm_busy",     busy, 1);
        chk("rearm_count",    sts_count, 0);
        exp_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            s_axis_tvalid = gap_pat[i];
            s_axis_tdata  = 32'hB0 + i;
            start         = (i == 1 || i == 2);
            cfg_length    = (i == 1 || i == 2) ? 17'd7 : 17'd3;
            if (gap_pat[i]) begin
                push_wr(exp_cnt, 32'hB0 + i);
                exp_cnt++;
            end
            cyc();
            chk("gap_count", sts_count, exp_cnt);
        end
        s_axis_tvalid = 1'b0;
        start         = 1'b0;
        chk("gap_done", done, 1);
        cyc();
        chk("gap_switch_drop", switch, 0);

        // Zero length: straight to DONE, no writes, switch stays low
        cfg_length = 0;
        start      = 1'b1;
        cyc();
        start         = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hDEAD;
        chk("zero_done",   done, 1);
        chk("zero_busy",   busy, 0);
        chk("zero_switch", switch, 0);
        chk("zero_count",  sts_count, 0);
        cyc();
        cyc();
        chk("zero_switch_stay", switch, 0);
        chk("zero_we",          bram_porta_we, 0);
        s_axis_tvalid = 1'b0;

        // Reset mid-capture after 2 of 8 writes; start asserted with reset loses
        cfg_length = 8;
        start      = 1'b1;
        cyc();
        start         = 1'b0;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_axis_tdata = 32'hC0 + i;
            push_wr(i, 32'hC0 + i);
            cyc();
        end
        chk("mid_count", sts_count, 2);
        rst          = 1'b1;
        start        = 1'b1;
        s_axis_tdata = 32'hC2;
        cyc();
        rst           = 1'b0;
        start         = 1'b0;
        s_axis_tvalid = 1'b0;
        chk("mid_rst_busy",   busy, 0);
        chk("mid_rst_done",   done, 0);
        chk("mid_rst_switch", switch, 0);
        chk("mid_rst_we",     bram_porta_we, 0);
        chk("mid_rst_count",  sts_count, 0);
        chk("mid_rst_addr",   bram_porta_addr, 0);
        cyc();

        // Oversized length clamps to the full depth, last write at 0x7FFF, no wrap
        cfg_length = 17'd32773;
        start      = 1'b1;
        cyc();
        start         = 1'b0;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 32768; i++) begin
            s_axis_tdata = 32'h5A000000 ^ i;
            push_wr(i, 32'h5A000000 ^ i);
            cyc();
        end
        chk("big_done",     done, 1);
        chk("big_count",    sts_count, 32768);
        chk("big_last_addr", bram_porta_addr, 15'h7FFF);
        // Keep tvalid high: any further write would be flagged by the monitor.
        cyc();
        cyc();
        s_axis_tvalid = 1'b0;
        chk("big_switch_drop", switch, 0);
        chk("big_count_hold",  sts_count, 32768);

        cyc();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bram_capture_writer.md
BRAM_CAPTURE_WRITER -- requirements
Module: bram_capture_writer

Interface
REQ-001 SHALL have parameter BRAM_DATA_WIDTH, default 32: sample and BRAM data width.
REQ-002 SHALL have parameter BRAM_ADDR_WIDTH, default 15: BRAM word-address width; depth 2^BRAM_ADDR_WIDTH.
REQ-003 SHALL have port clk  in  1: single clock for all logic.
REQ-004 SHALL have port rst  in  1: reset, synchronous and active-high.
REQ-005 SHALL have port cfg_length  in  BRAM_ADDR_WIDTH+1: number of words to capture.
REQ-006 SHALL have port start  in  1: one-cycle capture request.
REQ-007 SHALL have port s_axis_tdata  in  BRAM_DATA_WIDTH: sample stream data.
REQ-008 SHALL have port s_axis_tvalid  in  1: sample valid.
REQ-009 SHALL have port s_axis_tready  out  1: sample ready.
REQ-010 SHALL have port bram_porta_clk  out  1: BRAM port A clock.
REQ-011 SHALL have port bram_porta_rst  out  1: BRAM port A reset.
REQ-012 SHALL have port bram_porta_addr  out  BRAM_ADDR_WIDTH: BRAM word address.
REQ-013 SHALL have port bram_porta_wrdata  out  BRAM_DATA_WIDTH: BRAM write data.
REQ-014 SHALL have port bram_porta_we  out  1: BRAM write enable.
REQ-015 SHALL have port bram_porta_rddata  in  BRAM_DATA_WIDTH: read data, unused.
REQ-016 SHALL have port switch  out  1: 1 = writer owns BRAM (port A); 0 = BRAM handed to reader (port B).
REQ-017 SHALL have port busy  out  1: high while in CAPTURE.
REQ-018 SHALL have port done  out  1: high while in DONE.
REQ-019 SHALL have port sts_count  out  BRAM_ADDR_WIDTH+1: words written in the current or last capture.

Function
REQ-020 SHALL drive bram_porta_clk = clk and bram_porta_rst = rst combinationally.
REQ-021 SHALL tie s_axis_tready to 1 in all states; samples outside CAPTURE are discarded.
REQ-022 SHALL implement states IDLE, CAPTURE and DONE; busy and done SHALL be decoded from the state register.
REQ-023 SHALL latch eff_len on each start accepted in IDLE or DONE: eff_len = min(cfg_length, 2^BRAM_ADDR_WIDTH).
REQ-024 SHALL perform the following on an accepted start with eff_len != 0: go to CAPTURE, clear count, set switch <= 1.
REQ-025 SHALL, on an accepted start with eff_len = 0, go directly to DONE with no writes, count = 0 and switch held at 0.
REQ-026 SHALL ignore start while in CAPTURE.
REQ-027 SHALL, on each CAPTURE edge with tvalid = 1, register we <= 1, addr <= count[BRAM_ADDR_WIDTH-1:0] and wrdata <= tdata, then increment count. Write latency is 1 cycle.
REQ-028 SHALL register we <= 0 on every other edge; addr and wrdata hold their values.
REQ-029 SHALL go to DONE on the accepting edge when count+1 = eff_len; the last word is written at the full address 2^BRAM_ADDR_WIDTH-1 without wrap.
REQ-030 SHALL clear switch on the first edge in DONE, which is the same edge that the last we=1 is sampled by the BRAM; switch therefore never toggles while a write is pending.
REQ-031 SHALL present sts_count = count at all times; count holds its value in DONE until the next accepted start.
REQ-032 SHALL re-arm from DONE on start, clearing done on that edge.
REQ-033 SHALL leave count and addr unchanged by tvalid gaps in CAPTURE.

Reset
REQ-034 SHALL, with rst high at an edge, force state = IDLE, switch = 0, we = 0, addr = 0, wrdata = 0, count = 0 and eff_len = 0; this includes reset mid-capture.
REQ-035 SHALL give rst priority over start and tvalid in the same cycle.

Verification
REQ-036 SHALL verify basic capture: cfg_length = 4, start, tvalid continuous with data 0xA0..0xA3 -> we pulses at addr 0..3 with data A0..A3; done = 1 and switch = 0 one cycle after the last we; sts_count = 4.
REQ-037 SHALL verify gaps: cfg_length = 3 with tvalid pattern 1,0,0,1,1 -> exactly 3 writes at addr 0,1,2; no write during gaps.
REQ-038 SHALL verify the boundaries: cfg_length = 0 -> DONE next cycle with no we and switch stays 0; cfg_length = 2^15+5 -> 32768 writes, last at addr 0x7FFF, no wrap.
REQ-039 SHALL verify start handling: start asserted mid-capture is ignored; start in DONE -> new capture from addr 0 and done drops.
REQ-040 SHALL verify reset mid-capture: rst high after 2 of 8 writes -> next cycle state IDLE, switch = 0, we = 0, sts_count = 0.
